// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;

  // Same-cycle write collision priority: 1 means port B wins over port A.
  localparam bit BYP_B_OVER_A = 1'b1;

  function automatic int rf_aw(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue, cleared by writeback.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = rf_aw(NREG)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wa_en,
  input  logic [AW-1:0]   i_wa_addr,
  input  logic            i_wb_en,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic            i_iss_en,
  input  logic [AW-1:0]   i_iss_rd,
  output logic [NREG-1:0] o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_nxt;

  // Set is applied after clears so a new producer keeps the register pending.
  always_comb begin
    w_nxt = r_busy;
    if (i_wa_en)  w_nxt[i_wa_addr] = 1'b0;
    if (i_wb_en)  w_nxt[i_wb_addr] = 1'b0;
    if (i_iss_en) w_nxt[i_iss_rd]  = 1'b1;
    w_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_busy <= '0;
    else         r_busy <= w_nxt;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with x0 hardwired to zero and a busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = rf_aw(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]    rs_busy,
  input  logic              wa_en,
  input  logic [AW-1:0]     wa_addr,
  input  logic [XLEN-1:0]   wa_data,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic [NREG-1:0]   busy_vec
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] w_hit_a, w_hit_b, w_sel_a, w_sel_b;

  always_comb begin
    w_hit_a = '0;
    w_hit_b = '0;
    for (int i = 1; i < NREG; i++) begin
      w_hit_a[i] = wa_en && (wa_addr == AW'(i));
      w_hit_b[i] = wb_en && (wb_addr == AW'(i));
    end
    w_sel_b = w_hit_b & ({NREG{BYP_B_OVER_A}} | ~w_hit_a);
    w_sel_a = w_hit_a & ~w_sel_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_sel_b[i])      r_regs[i] <= wb_data;
        else if (w_sel_a[i]) r_regs[i] <= wa_data;
      end
    end
  end

  rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wa_en   (wa_en),
    .i_wa_addr (wa_addr),
    .i_wb_en   (wb_en),
    .i_wb_addr (wb_addr),
    .i_iss_en  (iss_en),
    .i_iss_rd  (iss_rd),
    .o_busy    (busy_vec)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_stored;
    assign w_addr   = rs_addr[p*AW +: AW];
    assign w_stored = (w_addr == '0) ? '0 : r_regs[w_addr];
`ifdef REGFILE_BYPASS_EN
    logic w_ha, w_hb, w_fb, w_fa;
    assign w_ha = wa_en && (wa_addr == w_addr) && (w_addr != '0);
    assign w_hb = wb_en && (wb_addr == w_addr) && (w_addr != '0);
    assign w_fb = w_hb && (BYP_B_OVER_A || !w_ha);
    assign w_fa = w_ha && !w_fb;
    // A forwarded write retires the producer unless a new one issues this cycle.
    assign rs_data[p*XLEN +: XLEN] = reset ? '0 :
                                     w_fb  ? wb_data :
                                     w_fa  ? wa_data : w_stored;
    assign rs_busy[p] = reset ? 1'b0 :
                        (w_ha || w_hb) ? (iss_en && (iss_rd == w_addr)) : busy_vec[w_addr];
`else
    assign rs_data[p*XLEN +: XLEN] = reset ? '0 : w_stored;
    assign rs_busy[p] = reset ? 1'b0 : busy_vec[w_addr];
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus pushes expected reads, a negedge monitor compares.
module tb_reg_file_mp;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int AW   = rf_aw(NREG);

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NRD*AW-1:0]    rs_addr;
  logic [NRD*XLEN-1:0]  rs_data;
  logic [NRD-1:0]       rs_busy;
  logic                 wa_en, wb_en, iss_en;
  logic [AW-1:0]        wa_addr, wb_addr, iss_rd;
  logic [XLEN-1:0]      wa_data, wb_data;
  logic [NREG-1:0]      busy_vec;

  reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*XLEN-1:0] d;
    logic [NRD-1:0]      b;
    logic [NREG-1:0]     v;
  } exp_t;

  exp_t            q[$];
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_bsy [NREG];
  int              n_tests = 0;
  int              n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: architectural register/pending state, reads see it plus optional forwarding.
  function automatic exp_t model_exp();
    exp_t e;
    e.d = '0; e.b = '0; e.v = '0;
    if (!reset) begin
      for (int r = 0; r < NREG; r++) e.v[r] = m_bsy[r];
      for (int p = 0; p < NRD; p++) begin
        int a;
        logic [XLEN-1:0] dat;
        logic bsy;
        a   = int'(rs_addr[p*AW +: AW]);
        dat = (a == 0) ? '0 : m_mem[a];
        bsy = m_bsy[a];
`ifdef REGFILE_BYPASS_EN
        if (a != 0 && wb_en && int'(wb_addr) == a) begin
          dat = wb_data; bsy = iss_en && int'(iss_rd) == a;
        end else if (a != 0 && wa_en && int'(wa_addr) == a) begin
          dat = wa_data; bsy = iss_en && int'(iss_rd) == a;
        end
`endif
        e.d[p*XLEN +: XLEN] = dat;
        e.b[p] = bsy;
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin m_mem[r] = '0; m_bsy[r] = 0; end
    end else begin
      if (wa_en && wa_addr != 0) m_mem[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
      if (wa_en) m_bsy[wa_addr] = 0;
      if (wb_en) m_bsy[wb_addr] = 0;
      if (iss_en && iss_rd != 0) m_bsy[iss_rd] = 1;
      m_bsy[0] = 0;
    end
  endtask

  task automatic step();
    q.push_back(model_exp());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; iss_en = 0;
  endtask

  task automatic rd_all(input logic [AW-1:0] a);
    rs_addr = {NRD{a}};
  endtask

  function automatic logic [AW-1:0] ra();
    case ($urandom_range(0, 8))
      0: return 5'd0;
      1: return 5'd3;
      2: return 5'd7;
      3: return 5'd9;
      4: return 5'd12;
      default: return AW'($urandom_range(0, NREG-1));
    endcase
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs_data", 128'(rs_data), 128'(e.d));
      chk("rs_busy", 128'(rs_busy), 128'(e.b));
      chk("busy_vec", 128'(busy_vec), 128'(e.v));
    end
  end

  initial begin
    for (int r = 0; r < NREG; r++) begin m_mem[r] = '0; m_bsy[r] = 0; end
    idle();
    wa_addr = '0; wb_addr = '0; iss_rd = '0; wa_data = '0; wb_data = '0;
    rs_addr = '0;
    reset = 1'b1;
    #12;
    chk("reset_busy_vec", 128'(busy_vec), 128'd0);
    chk("reset_rs_data", 128'(rs_data), 128'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // x5 write, then x0 write discarded
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; rd_all(5); step();
    idle(); #1;
    chk("x5_read", 128'(rs_data[XLEN-1:0]), 128'(32'hDEADBEEF));
    step();
    wa_en = 1; wa_addr = 0; wa_data = 32'h1234; rd_all(0); step();
    idle(); #1;
    chk("x0_read", 128'(rs_data[XLEN-1:0]), 128'd0);
    step();

    // A/B collision on x7
    wa_en = 1; wa_addr = 7; wa_data = 32'h11;
    wb_en = 1; wb_addr = 7; wb_data = 32'h22; rd_all(7); step();
    idle(); #1;
    chk("x7_b_wins", 128'(rs_data[XLEN-1:0]), 128'(32'h22));
    step();

    // busy set, clear, set-wins
    iss_en = 1; iss_rd = 9; rd_all(9); step();
    idle(); #1;
    chk("busy9_set", 128'(busy_vec[9]), 128'd1);
    wb_en = 1; wb_addr = 9; wb_data = 32'h99; step();
    idle(); #1;
    chk("busy9_clr", 128'(busy_vec[9]), 128'd0);
    iss_en = 1; iss_rd = 9; wa_en = 1; wa_addr = 9; wa_data = 32'h77; step();
    idle(); #1;
    chk("busy9_setwins", 128'(busy_vec[9]), 128'd1);
    step();

    // same-cycle write and read of x3
    wa_en = 1; wa_addr = 3; wa_data = 32'hA5A5A5A5; rd_all(3); step();
    idle(); step();

    // all ports on x12 while B writes it
    wb_en = 1; wb_addr = 12; wb_data = 32'h0C0C_1212; rd_all(12); step();
    idle(); step();

    // load everything, mark all pending, then reset mid-cycle
    for (int r = 1; r < NREG; r++) begin
      wa_en = 1; wa_addr = AW'(r); wa_data = $urandom();
      iss_en = 1; iss_rd = AW'(r); rd_all(AW'(r)); step();
    end
    idle(); step();
    wa_en = 1; wa_addr = 4; wa_data = 32'h5555_AAAA; iss_en = 1; iss_rd = 6; rd_all(4);
    #2; reset = 1'b1; #1;
    chk("midrst_busy_vec", 128'(busy_vec), 128'd0);
    chk("midrst_rs_data", 128'(rs_data), 128'd0);
    chk("midrst_rs_busy", 128'(rs_busy), 128'd0);
    step();
    #2; reset = 1'b0;
    step();
    idle(); #1;
    chk("post_rst_x4", 128'(rs_data[XLEN-1:0]), 128'(32'h5555_AAAA));
    step();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      wa_en = $urandom_range(0, 1); wa_addr = ra(); wa_data = $urandom();
      wb_en = $urandom_range(0, 1); wb_addr = ra(); wb_data = $urandom();
      iss_en = $urandom_range(0, 1); iss_rd = ra();
      for (int p = 0; p < NRD; p++) rs_addr[p*AW +: AW] = ra();
      step();
    end
    idle(); step();

    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
